// File: rtl/btn_conditioner_if.sv
// Conditioned push-button event bundle: debounced level plus the one-cycle
// press/release/short/long/repeat strobes handed to the mode counters.
interface btn_conditioner_if;
    logic btn_level;
    logic btn_pe;
    logic btn_ne;
    logic btn_short;
    logic btn_long;
    logic btn_rpt;

    modport master (output btn_level, btn_pe, btn_ne, btn_short, btn_long, btn_rpt);
    modport slave  (input  btn_level, btn_pe, btn_ne, btn_short, btn_long, btn_rpt);
endinterface

// File: rtl/btn_conditioner.sv
// Push-button front end: 2-FF synchroniser, counter debounce, press/release
// strobes, short/long press classification and auto-repeat while held.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | button released, waiting for a debounced press
//   PRESSED | press accepted, counting towards the long-press threshold
//   LONG    | long press reached, emitting auto-repeat strobes while held
module btn_conditioner #(
    parameter bit ACTIVE_LOW    = 1'b1,
    parameter int DB_CYCLES     = 1_000_000,
    parameter int LONG_CYCLES   = 100_000_000,
    parameter int REPEAT_CYCLES = 20_000_000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              btn_i,
    btn_conditioner_if.master btn_o
);
    localparam int DW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam int RW = (REPEAT_CYCLES < 2) ? 1 : $clog2(REPEAT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2
    } state_t;

    logic          sync1_q, sync2_q;
    logic          pressed_s;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic          level_q, level_d, level_dly_q;
    logic          pe_d, ne_d, pe_q, ne_q;
    state_t        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [RW-1:0] rep_q, rep_d;
    logic          short_q, short_d, long_q, long_d, rpt_q, rpt_d;

    // Two-stage synchroniser; reset value is the released pin level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= ACTIVE_LOW;
            sync2_q <= ACTIVE_LOW;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    assign pressed_s = sync2_q ^ ACTIVE_LOW;

    // Debounce: accept a new level after DB_CYCLES consecutive disagreeing samples.
    always_comb begin
        db_cnt_d = '0;
        level_d  = level_q;
        if (pressed_s != level_q) begin
            if (db_cnt_q == DW'(DB_CYCLES - 1)) begin
                level_d = ~level_q;
            end else begin
                db_cnt_d = db_cnt_q + DW'(1);
            end
        end
    end

    // Edge strobes come from the level and its one-cycle-old copy, so they
    // trail the level change by one cycle and can never overlap.
    assign pe_d =  level_q & ~level_dly_q;
    assign ne_d = ~level_q &  level_dly_q;

    // Debounce and strobe registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_cnt_q    <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            pe_q        <= 1'b0;
            ne_q        <= 1'b0;
        end else begin
            db_cnt_q    <= db_cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
            pe_q        <= pe_d;
            ne_q        <= ne_d;
        end
    end

    // Press classifier. It runs on the pre-register strobes so btn_short,
    // btn_long and btn_rpt land in the same cycle as btn_pe/btn_ne timing.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        rep_d   = rep_q;
        short_d = 1'b0;
        long_d  = 1'b0;
        rpt_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                hold_d = '0;
                rep_d  = '0;
                if (pe_d) begin
                    state_d = ST_PRESSED;
                    hold_d  = HW'(1);
                end
            end
            ST_PRESSED: begin
                // Release is tested first so it wins over the long threshold.
                if (ne_d) begin
                    short_d = 1'b1;
                    state_d = ST_IDLE;
                    hold_d  = '0;
                end else if (hold_q == HW'(LONG_CYCLES)) begin
                    long_d  = 1'b1;
                    rpt_d   = 1'b1;
                    state_d = ST_LONG;
                    rep_d   = RW'(1);
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            ST_LONG: begin
                if (ne_d) begin
                    state_d = ST_IDLE;
                    hold_d  = '0;
                    rep_d   = '0;
                end else if (REPEAT_CYCLES != 0) begin
                    if (rep_q == RW'(REPEAT_CYCLES)) begin
                        rpt_d = 1'b1;
                        rep_d = RW'(1);
                    end else begin
                        rep_d = rep_q + RW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                hold_d  = '0;
                rep_d   = '0;
            end
        endcase
    end

    // Classifier state, counters and event outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            rep_q   <= '0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            rpt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            rep_q   <= rep_d;
            short_q <= short_d;
            long_q  <= long_d;
            rpt_q   <= rpt_d;
        end
    end

    assign btn_o.btn_level = level_q;
    assign btn_o.btn_pe    = pe_q;
    assign btn_o.btn_ne    = ne_q;
    assign btn_o.btn_short = short_q;
    assign btn_o.btn_long  = long_q;
    assign btn_o.btn_rpt   = rpt_q;
endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: two instances (repeat period 5 and repeat off)
// share one pin. A per-cycle reference model predicts events into queues; a
// negedge monitor pops and compares whatever the DUTs present.
module tb_btn_conditioner;
    localparam int DB   = 4;
    localparam int L    = 20;
    localparam int R5   = 5;
    localparam int MAXC = 16384;

    typedef struct {
        int         cyc;
        logic [4:0] vec;   // {pe, ne, short, long, rpt}
    } ev_t;

    logic clk;
    logic reset_n;
    logic btn_i;

    btn_conditioner_if if0 ();
    btn_conditioner_if if1 ();

    btn_conditioner #(.ACTIVE_LOW(1'b1), .DB_CYCLES(DB), .LONG_CYCLES(L), .REPEAT_CYCLES(R5)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .btn_i(btn_i), .btn_o(if0.master));
    btn_conditioner #(.ACTIVE_LOW(1'b1), .DB_CYCLES(DB), .LONG_CYCLES(L), .REPEAT_CYCLES(0)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .btn_i(btn_i), .btn_o(if1.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- reference model ----------------
    int  cyc = 4;
    int  base = 0;
    bit  pin_h [MAXC];
    bit  lvl_h [MAXC];
    bit  active = 0;
    int  press_p = 0;
    bit  m_prev, m_flip, m_v, m_pe, m_ne, m_sh, m_lg, m_r5, m_r0;
    int  m_age;
    ev_t q0[$];
    ev_t q1[$];
    ev_t ev;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (cyc >= MAXC - 2) begin
                $display("FAIL model_overflow cycle=%0d limit=%0d", cyc, MAXC);
                $fatal(1);
            end
            if (!reset_n) begin
                pin_h[cyc] = 1'b0;
                lvl_h[cyc] = 1'b0;
                base       = cyc + 1;
                active     = 1'b0;
            end else begin
                pin_h[cyc] = (btn_i == 1'b0);
                // Level flips once the last DB synchronised samples all disagree with it.
                m_prev = lvl_h[cyc-1];
                m_flip = 1'b1;
                for (int i = 2; i <= DB + 1; i++) begin
                    m_v = (cyc - i >= base) ? pin_h[cyc-i] : 1'b0;
                    if (m_v == m_prev) m_flip = 1'b0;
                end
                lvl_h[cyc] = m_flip ? ~m_prev : m_prev;
                m_pe = lvl_h[cyc-1] & ~lvl_h[cyc-2];
                m_ne = ~lvl_h[cyc-1] & lvl_h[cyc-2];
                m_sh = 1'b0; m_lg = 1'b0; m_r5 = 1'b0; m_r0 = 1'b0;
                if (m_pe) begin
                    press_p = cyc;
                    active  = 1'b1;
                end else if (active) begin
                    m_age = cyc - press_p;
                    if (m_ne) begin
                        m_sh   = (m_age <= L);
                        active = 1'b0;
                    end else if (m_age == L) begin
                        m_lg = 1'b1; m_r5 = 1'b1; m_r0 = 1'b1;
                    end else if (m_age > L && ((m_age - L) % R5) == 0) begin
                        m_r5 = 1'b1;
                    end
                end
                ev.cyc = cyc;
                ev.vec = {m_pe, m_ne, m_sh, m_lg, m_r5};
                if (ev.vec != 5'd0) q0.push_back(ev);
                ev.vec = {m_pe, m_ne, m_sh, m_lg, m_r0};
                if (ev.vec != 5'd0) q1.push_back(ev);
            end
        end
    end

    // ---------------- monitor ----------------
    int cnt_pe, cnt_ne, cnt_sh, cnt_lg, cnt_r5, cnt_r0;
    int rise_cyc = -1;
    int pe_cyc = -1;
    int long_cyc = -1;
    logic prev_lvl0 = 1'b0;

    task automatic clear_counts();
        cnt_pe = 0; cnt_ne = 0; cnt_sh = 0; cnt_lg = 0; cnt_r5 = 0; cnt_r0 = 0;
        rise_cyc = -1; pe_cyc = -1; long_cyc = -1;
    endtask

    task automatic mon_dut(input int d, input logic [4:0] got, input logic lvl);
        ev_t e;
        int  sz;
        sz = (d == 0) ? q0.size() : q1.size();
        while (sz > 0) begin
            e = (d == 0) ? q0[0] : q1[0];
            if (e.cyc >= cyc) break;
            checks++; errors++;
            $display("FAIL strobe_missed dut%0d cycle=%0d got=none required=%b", d, e.cyc, e.vec);
            if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            sz--;
        end
        e.cyc = -1;
        e.vec = 5'd0;
        if (sz > 0) e = (d == 0) ? q0[0] : q1[0];
        if (got != 5'd0 || e.cyc == cyc) begin
            checks++;
            if (e.cyc == cyc) begin
                if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                if (got !== e.vec) begin
                    errors++;
                    $display("FAIL strobes dut%0d cycle=%0d got=%b required=%b", d, cyc, got, e.vec);
                end
            end else begin
                errors++;
                $display("FAIL strobe_unexpected dut%0d cycle=%0d got=%b required=00000", d, cyc, got);
            end
        end
        checks++;
        if (lvl !== lvl_h[cyc]) begin
            errors++;
            $display("FAIL btn_level dut%0d cycle=%0d got=%b required=%b", d, cyc, lvl, lvl_h[cyc]);
        end
    endtask

    initial begin
        logic [4:0] g0, g1;
        clear_counts();
        forever begin
            @(negedge clk);
            g0 = {if0.btn_pe, if0.btn_ne, if0.btn_short, if0.btn_long, if0.btn_rpt};
            g1 = {if1.btn_pe, if1.btn_ne, if1.btn_short, if1.btn_long, if1.btn_rpt};
            mon_dut(0, g0, if0.btn_level);
            mon_dut(1, g1, if1.btn_level);
            if (g0[4]) begin cnt_pe++; if (pe_cyc < 0) pe_cyc = cyc; end
            if (g0[3]) cnt_ne++;
            if (g0[2]) cnt_sh++;
            if (g0[1]) begin cnt_lg++; if (long_cyc < 0) long_cyc = cyc; end
            if (g0[0]) cnt_r5++;
            if (g1[0]) cnt_r0++;
            if (if0.btn_level === 1'b1 && prev_lvl0 === 1'b0 && rise_cyc < 0) rise_cyc = cyc;
            prev_lvl0 = if0.btn_level;
        end
    end

    // ---------------- stimulus ----------------
    task automatic chk(input string name, input int got, input int req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    task automatic hold_pin(input logic v, input int n);
        btn_i = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_counts(input string name, input int pe, input int ne, input int sh,
                                 input int lg, input int r5, input int r0);
        chk({name, "_pe"},    cnt_pe, pe);
        chk({name, "_ne"},    cnt_ne, ne);
        chk({name, "_short"}, cnt_sh, sh);
        chk({name, "_long"},  cnt_lg, lg);
        chk({name, "_rpt"},   cnt_r5, r5);
        chk({name, "_rpt0"},  cnt_r0, r0);
    endtask

    function automatic int outs0();
        return int'({if0.btn_level, if0.btn_pe, if0.btn_ne, if0.btn_short, if0.btn_long, if0.btn_rpt});
    endfunction

    function automatic int outs1();
        return int'({if1.btn_level, if1.btn_pe, if1.btn_ne, if1.btn_short, if1.btn_long, if1.btn_rpt});
    endfunction

    int chg_cyc;
    int rel_cyc;

    initial begin
        reset_n = 1'b0;
        btn_i   = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs_dut0", outs0(), 0);
        chk("reset_outputs_dut1", outs1(), 0);
        #1 reset_n = 1'b1;
        hold_pin(1'b1, 5);

        // Short press of 10 cycles.
        clear_counts();
        chg_cyc = cyc;
        hold_pin(1'b0, 10);
        hold_pin(1'b1, 30);
        expect_counts("short_press", 1, 1, 1, 0, 0, 0);
        chk("debounce_latency", rise_cyc - chg_cyc, DB + 2);

        // Glitches shorter than the debounce window.
        clear_counts();
        repeat (5) begin
            hold_pin(1'b0, 3);
            hold_pin(1'b1, 6);
        end
        hold_pin(1'b1, 10);
        expect_counts("glitch", 0, 0, 0, 0, 0, 0);

        // 40-cycle hold: long press with repeats.
        clear_counts();
        hold_pin(1'b0, 40);
        hold_pin(1'b1, 30);
        expect_counts("long_press", 1, 1, 0, 1, 4, 1);
        chk("long_after_pe", long_cyc - pe_cyc, L);

        // Release around the long threshold; 20 makes btn_ne meet it exactly.
        clear_counts();
        hold_pin(1'b0, 19);
        hold_pin(1'b1, 30);
        expect_counts("hold19", 1, 1, 1, 0, 0, 0);
        clear_counts();
        hold_pin(1'b0, 20);
        hold_pin(1'b1, 30);
        expect_counts("hold20_tie", 1, 1, 1, 0, 0, 0);
        clear_counts();
        hold_pin(1'b0, 21);
        hold_pin(1'b1, 30);
        expect_counts("hold21", 1, 1, 0, 1, 1, 1);

        // Reset while in the long state with the pin still pressed.
        clear_counts();
        hold_pin(1'b0, 30);
        chk("pre_reset_long", cnt_lg, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("async_reset_dut0", outs0(), 0);
        chk("async_reset_dut1", outs1(), 0);
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;
        rel_cyc = cyc;
        clear_counts();
        hold_pin(1'b0, 40);
        hold_pin(1'b1, 30);
        chk("reset_level_rise", rise_cyc - rel_cyc, DB + 2);
        chk("reset_long_after_pe", long_cyc - pe_cyc, L);
        expect_counts("after_reset", 1, 1, 0, 1, 4, 1);

        // Random pin activity: glitches, short and long presses.
        for (int i = 0; i < 150; i++) begin
            hold_pin(i[0] ? 1'b1 : 1'b0, $urandom_range(1, 30));
        end
        hold_pin(1'b1, 40);

        chk("queue0_drained", q0.size(), 0);
        chk("queue1_drained", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
